// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor built from 4-bit
// full-lookahead groups, GROUPS_PER_STAGE groups resolved per register stage,
// valid/ready handshake on both sides.
// Optional feature: define CLA_PIPE_SAT_EN for signed saturation of the result.
module cla_pipe #(
    parameter int unsigned WIDTH            = 16,
    parameter int unsigned GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NGROUP = WIDTH / 4;
    localparam int unsigned GPS    = (GROUPS_PER_STAGE == 0) ? 1 : GROUPS_PER_STAGE;
    localparam int unsigned NSTAGE = (NGROUP / GPS == 0) ? 1 : NGROUP / GPS;
    localparam int unsigned SW     = 4 * GPS;

    // Reject unsupported configurations at elaboration
    if (WIDTH < 4 || (WIDTH % 4) != 0 || GROUPS_PER_STAGE == 0 || (NGROUP % GPS) != 0) begin : g_bad_cfg
        $error("cla_pipe: WIDTH must be a multiple of 4 (>=4) and GROUPS_PER_STAGE must divide WIDTH/4");
    end

    // Full lookahead carries c1..c4 of one 4-bit group, no internal ripple
    function automatic logic [4:1] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic c0);
        logic [4:1] c;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Per-stage registers: operands travel with the beat, sum fills in slice by slice
    logic             st_vld [NSTAGE];
    logic [WIDTH-1:0] st_a   [NSTAGE];
    logic [WIDTH-1:0] st_b   [NSTAGE];
    logic [WIDTH-1:0] st_s   [NSTAGE];
    logic             st_c   [NSTAGE];
    logic             st_ovf [NSTAGE];

    logic en;

    // Whole pipeline advances unless a finished result is waiting on the consumer
    assign en        = !st_vld[NSTAGE-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = st_vld[NSTAGE-1];
    assign sum       = st_s[NSTAGE-1];
    assign cout      = st_c[NSTAGE-1];
    assign ovf       = st_ovf[NSTAGE-1];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic             vld_i;
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic [GPS:0]     gc;
        logic [SW-1:0]    gs;
        logic             cm;
        logic [WIDTH-1:0] s_n;
        logic [WIDTH-1:0] res_n;
        logic             c_n;
        logic             ovf_n;

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + 1
            assign vld_i = in_valid;
            assign a_i   = a;
            assign b_i   = sub ? ~b : b;
            assign s_i   = '0;
            assign c_i   = sub | cin;
        end else begin : g_next
            assign vld_i = st_vld[k-1];
            assign a_i   = st_a[k-1];
            assign b_i   = st_b[k-1];
            assign s_i   = st_s[k-1];
            assign c_i   = st_c[k-1];
        end

        assign gc[0] = c_i;

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            localparam int unsigned LO = (k * GPS + j) * 4;
            logic [3:0] p;
            logic [3:0] g;
            logic [4:1] c;

            // One 4-bit group; group carry hands off to the next group in this stage
            assign p              = a_i[LO +: 4] ^ b_i[LO +: 4];
            assign g              = a_i[LO +: 4] & b_i[LO +: 4];
            assign c              = grp_carry(p, g, gc[j]);
            assign gs[4*j +: 4]   = p ^ {c[3:1], gc[j]};
            assign gc[j+1]        = c[4];
            if (j == GPS - 1) begin : g_msb
                assign cm = c[3];
            end
        end

        assign c_n   = gc[GPS];
        assign ovf_n = cm ^ c_n;

        // Merge this stage's slice into the partially resolved sum
        always_comb begin
            s_n = s_i;
            s_n[k*SW +: SW] = gs;
        end

        if (k == NSTAGE - 1) begin : g_out
`ifdef CLA_PIPE_SAT_EN
            localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
            localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
            // Clamp toward the sign of A on signed overflow
            always_comb begin
                res_n = s_n;
                if (ovf_n) res_n = a_i[WIDTH-1] ? SMIN : SMAX;
            end
`else
            assign res_n = s_n;
`endif
        end else begin : g_mid
            assign res_n = s_n;
        end

        // Stage register: cleared by reset, frozen while the pipeline is stalled
        always_ff @(posedge clk) begin
            if (rst) begin
                st_vld[k] <= 1'b0;
                st_a[k]   <= '0;
                st_b[k]   <= '0;
                st_s[k]   <= '0;
                st_c[k]   <= 1'b0;
                st_ovf[k] <= 1'b0;
            end else if (en) begin
                st_vld[k] <= vld_i;
                st_a[k]   <= a_i;
                st_b[k]   <= b_i;
                st_s[k]   <= res_n;
                st_c[k]   <= c_n;
                st_ovf[k] <= ovf_n;
            end
        end
    end

endmodule
